// File: rtl/zbuf_fetch_if.sv
// Fragment-in, Z-buffer read and Z-test/write-out signal bundle for zbuf_fetch.
// The slave modport is the fetch unit's view; master is the surrounding environment.
`timescale 1ns/1ps

interface zbuf_fetch_if #(
    parameter int ADDR_W = 19
);
    logic              frag_valid;
    logic              frag_ready;
    logic [9:0]        frag_x;
    logic [8:0]        frag_y;
    logic [17:0]       frag_z;
    logic [15:0]       frag_color;
    logic              frag_clear;

    logic              zb_rd_en;
    logic [ADDR_W-1:0] zb_rd_addr;
    logic [17:0]       zb_rd_data;

    logic [ADDR_W-1:0] out_addr;
    logic [17:0]       pixelZ;
    logic [17:0]       currZ;
    logic [15:0]       color_out;
    logic              rasterPixel;
    logic              clearPixel;
    logic [15:0]       drop_count;

    modport slave (
        input  frag_valid, frag_x, frag_y, frag_z, frag_color, frag_clear, zb_rd_data,
        output frag_ready, zb_rd_en, zb_rd_addr, out_addr, pixelZ, currZ, color_out,
               rasterPixel, clearPixel, drop_count
    );

    modport master (
        output frag_valid, frag_x, frag_y, frag_z, frag_color, frag_clear, zb_rd_data,
        input  frag_ready, zb_rd_en, zb_rd_addr, out_addr, pixelZ, currZ, color_out,
               rasterPixel, clearPixel, drop_count
    );
endinterface

// File: rtl/zbuf_fetch.sv
// Z-buffer read side: issues depth reads for fragments, carries each fragment alongside
// its read for RD_LAT cycles, and stalls same-pixel fragments until the earlier write lands.
`timescale 1ns/1ps

module zbuf_fetch #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    zbuf_fetch_if.slave  bus
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [17:0]       z;
        logic [15:0]       color;
        logic              clear;
    } stage_t;

    // Stage k holds the fragment issued k cycles ago; stage RD_LAT drives the outputs.
    stage_t            stage_q [1:RD_LAT];
    stage_t            stage_d [1:RD_LAT];
    logic [17:0]       currz_q, currz_d;
    logic [15:0]       drop_count_q, drop_count_d;

    logic [ADDR_W-1:0] frag_addr;
    logic              in_range;
    logic              addr_match;
    logic              hit;
    logic              ready;
    logic              accept;
    logic              issue;

    always_comb begin
        frag_addr = ADDR_W'(32'(bus.frag_y) * 32'(H_RES) + 32'(bus.frag_x));
        in_range  = (32'(bus.frag_x) < 32'(H_RES)) && (32'(bus.frag_y) < 32'(V_RES));
    end

    // A pixel still in flight has not been written yet, so a second read of it would be stale.
    always_comb begin
        addr_match = 1'b0;
        for (int k = 1; k <= RD_LAT; k++) begin
            if (stage_q[k].valid && (stage_q[k].addr == frag_addr)) begin
                addr_match = 1'b1;
            end
        end
        hit    = bus.frag_valid & in_range & addr_match;
        ready  = ~reset & ~hit;
        accept = bus.frag_valid & ready;
        issue  = accept & in_range;
    end

    always_comb begin
        // NOTE: every next-state variable is given a full default first so no path leaves it
        // unassigned; a missing default here would infer a latch instead of a mux.
        stage_d      = stage_q;
        currz_d      = currz_q;
        drop_count_d = drop_count_q;

        stage_d[1].valid = issue;
        if (issue) begin
            stage_d[1].addr  = frag_addr;
            stage_d[1].z     = bus.frag_z;
            stage_d[1].color = bus.frag_color;
            stage_d[1].clear = bus.frag_clear;
        end

        // Valid bits always shift; payload only moves with a valid fragment so the
        // final stage keeps its last data across bubbles.
        for (int k = 2; k <= RD_LAT; k++) begin
            stage_d[k].valid = stage_q[k-1].valid;
            if (stage_q[k-1].valid) begin
                stage_d[k] = stage_q[k-1];
            end
        end

        if (stage_q[RD_LAT].valid) begin
            currz_d = bus.zb_rd_data;
        end

        if (accept && !in_range && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the pipeline payload is cleared along with the valid bits because the
            // data outputs are defined as zero after reset, not merely don't-care.
            for (int k = 1; k <= RD_LAT; k++) begin
                stage_q[k] <= '0;
            end
            currz_q      <= '0;
            drop_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values,
            // independent of statement order.
            stage_q      <= stage_d;
            currz_q      <= currz_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign bus.frag_ready  = ready;
    assign bus.zb_rd_en    = issue;
    assign bus.zb_rd_addr  = issue ? frag_addr : '0;

    assign bus.out_addr    = stage_q[RD_LAT].addr;
    assign bus.pixelZ      = stage_q[RD_LAT].z;
    assign bus.color_out   = stage_q[RD_LAT].color;
    assign bus.currZ       = stage_q[RD_LAT].valid ? bus.zb_rd_data : currz_q;
    // Strobes are masked by reset so fragments in flight when reset hits never reach the writer.
    assign bus.rasterPixel = ~reset & stage_q[RD_LAT].valid & ~stage_q[RD_LAT].clear;
    assign bus.clearPixel  = ~reset & stage_q[RD_LAT].valid &  stage_q[RD_LAT].clear;
    assign bus.drop_count  = drop_count_q;

endmodule

// File: doc/zbuf_fetch.md
Name: zbuf_fetch

Overview:
- Read side of the depth/colour write path: accepts rasterised fragments, issues Z-buffer reads, and realigns the read data with the fragment.
- Presents pixelZ/currZ/color/rasterPixel/clearPixel plus the write address to the downstream Z-test/write stage, which writes the Z-buffer and framebuffer combinationally in the same cycle.
- Guarantees read-after-write ordering for fragments that hit the same pixel while earlier ones are still in flight.

Parameters:
H_RES, 640, horizontal resolution in pixels
V_RES, 480, vertical resolution in pixels
ADDR_W, 19, Z-buffer/framebuffer word address width
RD_LAT, 2, Z-buffer read latency in cycles, from zb_rd_en to zb_rd_data valid; legal range 1..4

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frag_valid  in  1  fragment offered
frag_ready  out  1  fragment accepted when frag_valid & frag_ready
frag_x  in  10  pixel x
frag_y  in  9  pixel y
frag_z  in  18  fragment depth (float18 format of compare unit)
frag_color  in  16  fragment colour RGB565
frag_clear  in  1  1 = clear-pixel op (no Z test), 0 = raster op
zb_rd_en  out  1  Z-buffer read strobe
zb_rd_addr  out  ADDR_W  Z-buffer read address
zb_rd_data  in  18  Z-buffer read data, valid RD_LAT cycles after zb_rd_en
out_addr  out  ADDR_W  write address for downstream stage
pixelZ  out  18  fragment depth
currZ  out  18  stored depth read from Z-buffer
color_out  out  16  fragment colour
rasterPixel  out  1  raster op valid this cycle
clearPixel  out  1  clear op valid this cycle
drop_count  out  16  saturating count of out-of-range fragments dropped

Behaviour:
- Reset: synchronous, active-high. All pipeline valid bits are 0. rasterPixel, clearPixel, zb_rd_en and frag_ready are 0. All data outputs and drop_count are 0. Reset asserted mid-operation discards every in-flight fragment; no output strobe is produced for them.
- Address: addr = frag_y*H_RES + frag_x, computed at full width and truncated to ADDR_W.
- Range check: a fragment with frag_x >= H_RES or frag_y >= V_RES is accepted (frag_ready follows the normal rule) but not issued. drop_count increments by 1 and saturates at 0xFFFF.
- Issue: on an accepted in-range fragment, zb_rd_en=1 and zb_rd_addr=addr in the same cycle, for clear ops as well.
- Pipeline: RD_LAT stages, each holding {valid, addr, z, color, clear}; advances unconditionally every cycle. There is no downstream backpressure.
- Output timing: a fragment issued in cycle t appears at the outputs in cycle t+RD_LAT, together with currZ=zb_rd_data.
  - rasterPixel = valid & ~clear.
  - clearPixel = valid & clear.
  - pixelZ, color_out and out_addr come from the final stage.
- Memory model: a read issued in the same cycle as a write to that address returns old data; the write is visible from the next cycle.
- Hazard: frag_ready = ~reset & ~hit, where hit = (frag_valid & in-range) & (addr equals addr of any valid stage 1..RD_LAT).
  - Stage k holds the fragment issued k cycles ago.
  - A same-address fragment therefore issues no earlier than t+RD_LAT+1.
  - Stalling inserts a bubble (zb_rd_en=0); the held fragment must stay stable at the input.
  - frag_ready is combinational from the inputs and the stage registers.
- Throughput: 1 fragment/cycle when addresses do not collide.
- Output data when idle: data outputs hold their last values and are don't-care while both strobes are 0.
- Strobe exclusivity: rasterPixel and clearPixel are never both 1.

Test Plan:
- Reset then stream 4 fragments to (0,0),(1,0),(2,0),(3,0) with RD_LAT=2 -> frag_ready held 1; zb_rd_en high cycles 0-3; rasterPixel high cycles 2-5; out_addr 0,1,2,3; currZ matches memory model.
- Back-to-back fragments to (5,1), z=0x10000 then 0x20000 -> second stalled 2 cycles (frag_ready=0); second issues at cycle 3; its currZ equals the value written by the first, if written.
- Fragment at (640,0) then (0,480) -> both accepted, no zb_rd_en, no output strobe; drop_count=2. Preset drop_count path to 0xFFFF, then drop again -> stays 0xFFFF.
- Clear fragment (10,10), color 0xFFFF -> clearPixel=1 at issue+2; rasterPixel=0; out_addr=6410.
- Reset asserted 1 cycle after issuing 2 fragments -> no rasterPixel/clearPixel follow; all outputs 0 on the next cycle.
- Random 10k fragments over an 8x8 region vs a reference model of the Z-test/write stage -> final Z-buffer matches sequential per-fragment processing; no stale currZ.
